// File: rtl/ibex_pkg.sv
// Shared types for the Ibex memory-port arbiter: source identifiers and a
// helper to name the opposite source.
package ibex_pkg;

  typedef enum logic {
    MemArbSrcInstr = 1'b0,
    MemArbSrcData  = 1'b1
  } mem_arb_src_e;

  function automatic mem_arb_src_e mem_arb_other(input mem_arb_src_e src);
    return (src == MemArbSrcData) ? MemArbSrcInstr : MemArbSrcData;
  endfunction

endpackage

// File: rtl/ibex_mem_arb_src_fifo.sv
// In-order FIFO of 1-bit source IDs, one entry per granted bus transaction
// still waiting for its response.
module ibex_mem_arb_src_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push,
  input  mem_arb_src_e    wdata,
  input  logic            pop,
  output mem_arb_src_e    head,
  output logic [CntW-1:0] count
);

  mem_arb_src_e        mem [Depth];
  logic     [PtrW-1:0] wr_ptr, rd_ptr;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; count gates every use of head,
  // so stale entries are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/ibex_mem_arbiter.sv
// Merges instruction-fetch and data ports onto one memory port with locked
// round-robin arbitration; responses are routed back by an in-order source FIFO.
module ibex_mem_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2,
  parameter logic [6:0]  IdleWdataIntg  = 7'h00
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic [31:0] instr_addr_i,
  output logic [31:0] instr_rdata_o,
  output logic [6:0]  instr_rdata_intg_o,
  output logic        instr_err_o,

  input  logic        data_req_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic [31:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o,

  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [6:0]  bus_wdata_intg_o,
  input  logic [31:0] bus_rdata_i,
  input  logic [6:0]  bus_rdata_intg_i,
  input  logic        bus_err_i,
  output logic        spurious_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  mem_arb_src_e    sel, rr_q, lock_src_q, head;
  logic            lock_q, spurious_q;
  logic            sel_req, not_full, push, pop, outstanding;
  logic [CntW-1:0] cnt;

  // A locked request keeps its source until granted; otherwise a lone
  // requester wins and ties (or idle) fall to the preferred source.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    sel = rr_q;
    if (lock_q)                        sel = lock_src_q;
    else if (instr_req_i && !data_req_i) sel = MemArbSrcInstr;
    else if (data_req_i && !instr_req_i) sel = MemArbSrcData;
  end

  assign sel_req     = (sel == MemArbSrcData) ? data_req_i : instr_req_i;
  assign not_full    = cnt < CntW'(MaxOutstanding);
  assign outstanding = cnt != '0;
  assign bus_req_o   = sel_req & not_full;
  assign push        = bus_req_o & bus_gnt_i;
  assign pop         = bus_rvalid_i & outstanding;

  assign instr_gnt_o = push & (sel == MemArbSrcInstr);
  assign data_gnt_o  = push & (sel == MemArbSrcData);

  always_comb begin
    bus_we_o         = 1'b0;
    bus_be_o         = 4'hF;
    bus_addr_o       = instr_addr_i;
    bus_wdata_o      = '0;
    bus_wdata_intg_o = IdleWdataIntg;
    if (sel == MemArbSrcData) begin
      bus_we_o         = data_we_i;
      bus_be_o         = data_be_i;
      bus_addr_o       = data_addr_i;
      bus_wdata_o      = data_wdata_i;
      bus_wdata_intg_o = data_wdata_intg_i;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q     <= 1'b0;
      lock_src_q <= MemArbSrcInstr;
      rr_q       <= MemArbSrcData;
      spurious_q <= 1'b0;
    end else begin
      if (bus_req_o && !bus_gnt_i) begin
        lock_q     <= 1'b1;
        lock_src_q <= sel;
      end else if (push) begin
        lock_q     <= 1'b0;
      end
      if (push) rr_q <= mem_arb_other(sel);
      spurious_q <= bus_rvalid_i & ~outstanding;
    end
  end

  ibex_mem_arb_src_fifo #(.Depth(MaxOutstanding)) u_src_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (sel),
    .pop    (pop),
    .head   (head),
    .count  (cnt)
  );

  assign instr_rvalid_o     = pop & (head == MemArbSrcInstr);
  assign data_rvalid_o      = pop & (head == MemArbSrcData);
  assign instr_rdata_o      = bus_rdata_i;
  assign instr_rdata_intg_o = bus_rdata_intg_i;
  assign instr_err_o        = bus_err_i;
  assign data_rdata_o       = bus_rdata_i;
  assign data_rdata_intg_o  = bus_rdata_intg_i;
  assign data_err_o         = bus_err_i;
  assign spurious_rvalid_o  = spurious_q;

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Directed, table-driven bench for ibex_mem_arbiter (MaxOutstanding=2).
module tb_ibex_mem_arbiter;

  localparam logic [31:0] IA   = 32'h0000_1000;
  localparam logic [31:0] DA   = 32'h0000_2000;
  localparam logic [31:0] DWD  = 32'hCAFE_F00D;
  localparam logic [3:0]  DBE  = 4'h3;
  localparam logic [6:0]  DWI  = 7'h2A;
  localparam logic [6:0]  IWI  = 7'h55;
  localparam logic [31:0] RD   = 32'h600D_D00D;
  localparam logic [6:0]  RDI  = 7'h33;

  logic        clk_i = 1'b0, rst_ni;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic [6:0]  instr_rdata_intg_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [6:0]  data_wdata_intg_i, data_rdata_intg_o;
  logic        bus_req_o, bus_gnt_i, bus_rvalid_i, bus_we_o, bus_err_i;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [6:0]  bus_wdata_intg_o, bus_rdata_intg_i;
  logic        spurious_rvalid_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  ibex_mem_arbiter #(.MaxOutstanding(2), .IdleWdataIntg(IWI)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o),
    .instr_rdata_intg_o(instr_rdata_intg_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_wdata_intg_i(data_wdata_intg_i),
    .data_rdata_o(data_rdata_o), .data_rdata_intg_o(data_rdata_intg_o), .data_err_o(data_err_o),
    .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wdata_intg_o(bus_wdata_intg_o),
    .bus_rdata_i(bus_rdata_i), .bus_rdata_intg_i(bus_rdata_intg_i), .bus_err_i(bus_err_i),
    .spurious_rvalid_o(spurious_rvalid_o)
  );

  typedef struct {
    logic ir, dr, g, rv;        // stimulus
    logic chk_mux, exp_d;       // check bus mux; expect data fields when exp_d
    logic breq, ig, dg, irv, drv, sp;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(input logic ir, dr, g, rv, cm, ed, breq, ig, dg, irv, drv, sp);
    vec_t v;
    v.ir = ir; v.dr = dr; v.g = g; v.rv = rv; v.chk_mux = cm; v.exp_d = ed;
    v.breq = breq; v.ig = ig; v.dg = dg; v.irv = irv; v.drv = drv; v.sp = sp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ir, dr, g, rv);
    instr_req_i = ir; data_req_i = dr; bus_gnt_i = g; bus_rvalid_i = rv;
  endtask

  task automatic check_ctrl(input string tag, input logic breq, ig, dg, irv, drv, sp);
    check({tag, " bus_req"},  32'(bus_req_o),         32'(breq));
    check({tag, " i_gnt"},    32'(instr_gnt_o),       32'(ig));
    check({tag, " d_gnt"},    32'(data_gnt_o),        32'(dg));
    check({tag, " i_rvalid"}, 32'(instr_rvalid_o),    32'(irv));
    check({tag, " d_rvalid"}, 32'(data_rvalid_o),     32'(drv));
    check({tag, " spurious"}, 32'(spurious_rvalid_o), 32'(sp));
  endtask

  initial begin
    // ir dr g rv cm ed | breq ig dg irv drv sp
    vecs[0]  = mk(0,0,0,0, 0,0, 0,0,0,0,0,0);
    vecs[1]  = mk(1,1,1,0, 1,1, 1,0,1,0,0,0);  // tie, rr=data after reset
    vecs[2]  = mk(1,1,1,1, 1,0, 1,1,0,0,1,0);
    vecs[3]  = mk(1,1,1,1, 1,1, 1,0,1,1,0,0);
    vecs[4]  = mk(1,1,1,1, 1,0, 1,1,0,0,1,0);
    vecs[5]  = mk(0,0,0,1, 0,0, 0,0,0,1,0,0);
    vecs[6]  = mk(1,0,1,0, 1,0, 1,1,0,0,0,0);
    vecs[7]  = mk(0,1,1,0, 1,1, 1,0,1,0,0,0);
    vecs[8]  = mk(1,1,1,0, 1,0, 0,0,0,0,0,0);  // full: no request
    vecs[9]  = mk(1,1,1,1, 1,0, 0,0,0,1,0,0);  // full + pop: no bypass
    vecs[10] = mk(1,1,1,0, 1,0, 1,1,0,0,0,0);
    vecs[11] = mk(0,0,0,1, 0,0, 0,0,0,0,1,0);
    vecs[12] = mk(0,0,0,1, 0,0, 0,0,0,1,0,0);
    vecs[13] = mk(0,0,0,1, 0,0, 0,0,0,0,0,0);  // rvalid with nothing outstanding
    vecs[14] = mk(0,0,0,0, 0,0, 0,0,0,0,0,1);
    vecs[15] = mk(0,0,0,0, 0,0, 0,0,0,0,0,0);
    vecs[16] = mk(1,0,0,0, 1,0, 1,0,0,0,0,0);  // instr stalls, gets locked
    vecs[17] = mk(1,1,0,0, 1,0, 1,0,0,0,0,0);
    vecs[18] = mk(1,1,0,0, 1,0, 1,0,0,0,0,0);
    vecs[19] = mk(1,1,1,0, 1,0, 1,1,0,0,0,0);
    vecs[20] = mk(1,1,1,0, 1,1, 1,0,1,0,0,0);

    rst_ni = 1'b0;
    drive(0, 0, 0, 0);
    instr_addr_i = IA; data_addr_i = DA; data_we_i = 1'b1; data_be_i = DBE;
    data_wdata_i = DWD; data_wdata_intg_i = DWI;
    bus_rdata_i = RD; bus_rdata_intg_i = RDI; bus_err_i = 1'b0;
    #2;
    check_ctrl("reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 21; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      @(negedge clk_i);
      drive(vecs[i].ir, vecs[i].dr, vecs[i].g, vecs[i].rv);
      #2;
      check_ctrl(tag, vecs[i].breq, vecs[i].ig, vecs[i].dg, vecs[i].irv, vecs[i].drv, vecs[i].sp);
      if (vecs[i].chk_mux) begin
        check({tag, " addr"},  bus_addr_o,               vecs[i].exp_d ? DA : IA);
        check({tag, " we"},    32'(bus_we_o),            vecs[i].exp_d ? 32'd1 : 32'd0);
        check({tag, " be"},    32'(bus_be_o),            vecs[i].exp_d ? 32'(DBE) : 32'hF);
        check({tag, " wdata"}, bus_wdata_o,              vecs[i].exp_d ? DWD : 32'h0);
        check({tag, " wintg"}, 32'(bus_wdata_intg_o),    vecs[i].exp_d ? 32'(DWI) : 32'(IWI));
      end
    end

    // Response payload goes to both sides regardless of rvalid.
    bus_err_i = 1'b1;
    #1;
    check("i_rdata", instr_rdata_o, RD);
    check("d_rdata", data_rdata_o, RD);
    check("i_rintg", 32'(instr_rdata_intg_o), 32'(RDI));
    check("d_rintg", 32'(data_rdata_intg_o), 32'(RDI));
    check("i_err",   32'(instr_err_o), 32'd1);
    check("d_err",   32'(data_err_o), 32'd1);
    bus_err_i = 1'b0;

    // Reset with two transactions outstanding; late responses become spurious.
    @(negedge clk_i);
    drive(0, 0, 0, 0);
    rst_ni = 1'b0;
    #2;
    check_ctrl("rst_mid", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(0, 0, 0, 1);
    #2;
    check_ctrl("late_rv1", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0);
    #2;
    check_ctrl("spur1", 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(0, 0, 0, 1);
    #2;
    check_ctrl("late_rv2", 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0);
    #2;
    check_ctrl("spur2", 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    drive(1, 1, 1, 0);
    #2;
    check_ctrl("post_rst_tie", 1, 0, 1, 0, 0, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
